// File: rtl/app_wr_channel.sv
// DMA write channel: requests the arbiter when a full burst sits in the FWFT FIFO,
// then streams BURST_LEN commands and BURST_LEN data beats into the MIG UI.
// Command and data sides handshake independently; start/end bracket each burst.
module app_wr_channel #(
  parameter int                DATA_W    = 128,
  parameter int                ADDR_W    = 28,
  parameter int                CNT_W     = 10,
  parameter int                BURST_LEN = 64,
  parameter int                ADDR_STEP = 8,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_W-1:0] ADDR_END  = 28'h07F_FFF8
) (
  input  logic                  I_clk,
  input  logic                  I_Rst_n,
  input  logic                  I_init_calib_complete,
  input  logic [CNT_W-1:0]      I_fifo_cnt,
  input  logic [DATA_W-1:0]     I_fifo_dout,
  output logic                  O_fifo_rd_en,
  output logic                  O_req,
  input  logic                  I_vaild,
  output logic                  O_start,
  output logic                  O_end,
  output logic [ADDR_W-1:0]     O_app_addr,
  output logic [2:0]            O_app_cmd,
  output logic                  O_app_en,
  input  logic                  I_app_rdy,
  output logic [DATA_W-1:0]     O_app_wdf_data,
  output logic                  O_app_wdf_wren,
  output logic                  O_app_wdf_end,
  output logic [DATA_W/8-1:0]   O_app_wdf_mask,
  input  logic                  I_app_wdf_rdy
);

  localparam logic [CNT_W-1:0] BL = CNT_W'(BURST_LEN);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_REQ   = 5'b00010,
    S_START = 5'b00100,
    S_BURST = 5'b01000,
    S_END   = 5'b10000
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cmd_cnt;
  logic [CNT_W-1:0]    data_cnt;
  logic [1:0]          gap_cnt;
  logic [ADDR_W-1:0]   addr;
  logic                cmd_acc;
  logic                data_acc;

  assign cmd_acc        = O_app_en & I_app_rdy;
  assign data_acc       = O_app_wdf_wren & I_app_wdf_rdy;
  assign O_fifo_rd_en   = data_acc;
  assign O_app_wdf_data = I_fifo_dout;
  assign O_app_wdf_end  = O_app_wdf_wren;
  assign O_app_wdf_mask = '0;
  assign O_app_cmd      = 3'b000;
  assign O_app_addr     = addr;

  // State register.
  always_ff @(posedge I_clk) begin
    if (!I_Rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and state-decoded outputs; END waits for the gap counter so the
  // arbiter, which sees start two cycles late, is already busy when end arrives.
  always_comb begin
    state_nxt      = state;
    O_req          = 1'b0;
    O_start        = 1'b0;
    O_end          = 1'b0;
    O_app_en       = 1'b0;
    O_app_wdf_wren = 1'b0;
    case (state)
      S_IDLE: begin
        if (I_init_calib_complete && (I_fifo_cnt >= BL)) state_nxt = S_REQ;
      end
      S_REQ: begin
        O_req = 1'b1;
        if (I_vaild) state_nxt = S_START;
      end
      S_START: begin
        O_start   = 1'b1;
        state_nxt = S_BURST;
      end
      S_BURST: begin
        O_app_en       = (cmd_cnt < BL);
        O_app_wdf_wren = (data_cnt < BL);
        if ((cmd_cnt == BL) && (data_cnt == BL)) state_nxt = S_END;
      end
      S_END: begin
        if (gap_cnt == 2'd3) begin
          O_end     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Beat counters: each side counts its own accepted handshakes; cleared in END.
  always_ff @(posedge I_clk) begin
    if (!I_Rst_n || (state == S_END)) begin
      cmd_cnt  <= '0;
      data_cnt <= '0;
    end else begin
      if (cmd_acc)  cmd_cnt  <= cmd_cnt + 1'b1;
      if (data_acc) data_cnt <= data_cnt + 1'b1;
    end
  end

  // Saturating cycle count since START (zero during the START cycle itself).
  always_ff @(posedge I_clk) begin
    if (!I_Rst_n || (state == S_IDLE) || (state == S_REQ)) gap_cnt <= 2'd0;
    else if (gap_cnt != 2'd3)                              gap_cnt <= gap_cnt + 2'd1;
  end

  // Command address: advances per accepted command, wraps at ADDR_END, persists across bursts.
  always_ff @(posedge I_clk) begin
    if (!I_Rst_n) begin
      addr <= ADDR_BASE;
    end else if (cmd_acc) begin
      if (addr == ADDR_END) addr <= ADDR_BASE;
      else                  addr <= addr + ADDR_W'(ADDR_STEP);
    end
  end

endmodule
